traffic_light_monitor: RTL
==========================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter: CNT_W, 24, width of phase-length counter.
REQ-002 Parameter: PHASE_MIN, 4, minimum legal length in cycles of any non-flash phase.
REQ-003 Parameter: FLASH_GAP_MAX, 16, maximum consecutive dark cycles tolerated inside flashing green.
REQ-004 Port: clk  input  1  system clock; all state on rising edge.
REQ-005 Port: res  input  1  asynchronous, active-high reset.
REQ-006 Port: led0  input  1  red lamp (1 = lit).
REQ-007 Port: led1  input  1  yellow lamp.
REQ-008 Port: led2  input  1  green lamp.
REQ-009 Port: phase  output  3  current FSM state code: INIT=0, RED=1, YEL1=2, GREEN=3, FLASH=4, YEL2=5.
REQ-010 Port: err  output  1  sticky error flag.
REQ-011 Port: err_code  output  3  code of first error: 0 none, 1 illegal pattern, 2 wrong sequence, 3 short phase, 4 flash gap.
REQ-012 Port: cycle_cnt  output  8  count of completed RED..YEL2..RED cycles, wraps 255->0.
REQ-013 Port: last_len  output  CNT_W  length in cycles of the most recently completed phase.

Function
REQ-014 {led2,led1,led0} SHALL be registered once; decode operates on the registered sample: 001 red, 010 yellow, 100 green, 000 dark, any other = illegal.
REQ-015 FSM SHALL update on the edge after sampling: phase reflects an LED change 2 clock edges after the change.
REQ-016 INIT: red -> RED; yellow, green, dark stay INIT; no sequence errors raised in INIT.
REQ-017 RED: red stays; yellow -> YEL1; green or dark -> error 2.
REQ-018 YEL1: yellow stays; green -> GREEN; red or dark -> error 2.
REQ-019 GREEN: green stays; dark -> FLASH; red or yellow -> error 2.
REQ-020 FLASH: green or dark stays; yellow -> YEL2; red -> error 2; dark run counter resets on each green sample; dark run exceeding FLASH_GAP_MAX consecutive cycles -> error 4.
REQ-021 YEL2: yellow stays; red -> RED and cycle_cnt increments; green or dark -> error 2.
REQ-022 Illegal pattern SHALL raise error 1 in every state including INIT.
REQ-023 Phase-length counter SHALL clear to 1 on entry to each state, increment per cycle in that state, and saturate at all-ones.
REQ-024 On each state exit from RED, YEL1, GREEN, YEL2, FLASH, last_len SHALL load the counter value; exit from RED, YEL1, GREEN or YEL2 with length < PHASE_MIN -> error 3 (FLASH exempt).
REQ-025 Exits from INIT SHALL NOT update last_len or check length.
REQ-026 On any error: err set to 1 and held until reset; err_code loaded only if currently 0; FSM returns to INIT and resynchronises on the next red.
REQ-027 Simultaneous conditions in one cycle: priority 1 > 4 > 3 > 2; only the highest code is recorded.
REQ-028 A short-phase violation on a legal transition SHALL still send FSM to INIT (no partial advance).
REQ-029 cycle_cnt SHALL continue counting after err is set once resynchronised.

Reset
REQ-030 While res=1: phase=0, err=0, err_code=0, cycle_cnt=0, last_len=0, counters and sample register cleared (sample = dark), asynchronously, without waiting for clk.
REQ-031 Reset asserted mid-phase SHALL abandon the phase with no error and no last_len update; after release FSM starts in INIT.

Verification
REQ-032 Legal cycle: red 10, yellow 5, green 20, flash (green 3/dark 3) x4, yellow 5, red 10 cycles -> phases 1,2,3,4,5,1 in order, err=0, cycle_cnt=1, last_len=5 after YEL2 exit.
REQ-033 Illegal pattern: from RED apply 011 for one cycle -> err=1, err_code=1, phase=0 two edges later.
REQ-034 Wrong sequence: RED then green directly -> err_code=2, phase=0; subsequent legal cycle increments cycle_cnt, err_code stays 2.
REQ-035 Short phase: yellow held 2 cycles in YEL1 (PHASE_MIN=4) -> err_code=3 on green arrival, last_len=2.
REQ-036 Flash gap: in FLASH hold dark 17 cycles (FLASH_GAP_MAX=16) -> err_code=4; dark of exactly 16 then green -> no error.
REQ-037 Reset mid-GREEN: assert res asynchronously between edges -> all outputs 0 immediately; after release, red-first sequence runs error-free.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Traffic light sequence monitor.
// Samples the three lamp inputs once, tracks the RED -> YEL1 -> GREEN ->
// FLASH -> YEL2 -> RED sequence, measures every phase length and latches
// the first error seen (illegal pattern, wrong order, short phase or an
// over-long dark gap while flashing). Any error drops the tracker back to
// INIT, where it waits for the next red before following the lights again.
//
//   state | meaning
//   INIT  | waiting for red to (re)synchronise
//   RED   | red lit
//   YEL1  | yellow after red
//   GREEN | steady green
//   FLASH | green flashing (green/dark alternating)
//   YEL2  | yellow after flashing green, red closes the cycle
module traffic_light_monitor #(
    parameter int CNT_W         = 24,
    parameter int PHASE_MIN     = 4,
    parameter int FLASH_GAP_MAX = 16
) (
    input  logic             clk,
    input  logic             res,
    input  logic             led0,
    input  logic             led1,
    input  logic             led2,
    output logic [2:0]       phase,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [7:0]       cycle_cnt,
    output logic [CNT_W-1:0] last_len
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_RED   = 3'd1,
        S_YEL1  = 3'd2,
        S_GREEN = 3'd3,
        S_FLASH = 3'd4,
        S_YEL2  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LEN_MIN = CNT_W'(PHASE_MIN);
    localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(FLASH_GAP_MAX);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state;
    state_t           seq_next;
    state_t           next_state;
    logic [2:0]       lamps;
    logic [CNT_W-1:0] len_cnt;
    logic [CNT_W-1:0] dark_run;
    logic [CNT_W-1:0] dark_next;
    logic             is_red, is_yel, is_grn, is_dark, is_ill;
    logic             seq_err, gap_err, short_err, measured, raw_exit, any_err;
    logic [2:0]       code;

    // Single sampling stage for the lamp inputs; cleared to dark in reset.
    always_ff @(posedge clk or posedge res) begin
        if (res) lamps <= 3'b000;
        else     lamps <= {led2, led1, led0};
    end

    assign is_red  = (lamps == 3'b001);
    assign is_yel  = (lamps == 3'b010);
    assign is_grn  = (lamps == 3'b100);
    assign is_dark = (lamps == 3'b000);
    assign is_ill  = !(is_red || is_yel || is_grn || is_dark);

    // Legal-sequence next state and wrong-order detection.
    always_comb begin
        seq_next = state;
        seq_err  = 1'b0;
        case (state)
            S_INIT:  if (is_red) seq_next = S_RED;
            S_RED:   if (is_yel) seq_next = S_YEL1;
                     else if (is_grn || is_dark) seq_err = 1'b1;
            S_YEL1:  if (is_grn) seq_next = S_GREEN;
                     else if (is_red || is_dark) seq_err = 1'b1;
            S_GREEN: if (is_dark) seq_next = S_FLASH;
                     else if (is_red || is_yel) seq_err = 1'b1;
            S_FLASH: if (is_yel) seq_next = S_YEL2;
                     else if (is_red) seq_err = 1'b1;
            S_YEL2:  if (is_red) seq_next = S_RED;
                     else if (is_grn || is_dark) seq_err = 1'b1;
            default: seq_next = S_INIT;
        endcase
    end

    // Error classification; the highest-priority code wins (1 > 4 > 3 > 2).
    always_comb begin
        dark_next = dark_run + ONE;
        gap_err   = (state == S_FLASH) && is_dark && (dark_next > GAP_MAX);
        measured  = (state != S_INIT);
        raw_exit  = is_ill || gap_err || seq_err || (seq_next != state);
        short_err = measured && (state != S_FLASH) && raw_exit && (len_cnt < LEN_MIN);
        if (is_ill)         code = 3'd1;
        else if (gap_err)   code = 3'd4;
        else if (short_err) code = 3'd3;
        else if (seq_err)   code = 3'd2;
        else                code = 3'd0;
        any_err    = (code != 3'd0);
        next_state = any_err ? S_INIT : seq_next;
    end

    // Tracker state, phase timing, flash gap run and latched results.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state     <= S_INIT;
            len_cnt   <= '0;
            dark_run  <= '0;
            err       <= 1'b0;
            err_code  <= 3'd0;
            cycle_cnt <= 8'd0;
            last_len  <= '0;
        end else begin
            state <= next_state;

            if (next_state != state)  len_cnt <= ONE;
            else if (len_cnt != '1)   len_cnt <= len_cnt + ONE;

            if (measured && raw_exit) last_len <= len_cnt;

            if (next_state == S_FLASH) begin
                if (state != S_FLASH) dark_run <= ONE;
                else if (is_dark)     dark_run <= dark_next;
                else                  dark_run <= '0;
            end else begin
                dark_run <= '0;
            end

            if (any_err) begin
                err <= 1'b1;
                if (err_code == 3'd0) err_code <= code;
            end

            if (!any_err && state == S_YEL2 && seq_next == S_RED)
                cycle_cnt <= cycle_cnt + 8'd1;
        end
    end

    assign phase = state;

endmodule
